// File: rtl/pcie_dma_desc_issue_ctrl.sv
// Descriptor issue controller for one PCIe DMA mux port. It allocates sequential tags
// from a ring, limits the number of in-flight descriptors and retires status in issue order.
module pcie_dma_desc_issue_ctrl #(
  parameter int PCIE_ADDR_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 20,
  parameter int TAG_WIDTH       = 5,
  parameter int MAX_OUTSTANDING = 2**TAG_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,

  input  logic [PCIE_ADDR_WIDTH-1:0] s_axis_req_pcie_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axis_req_axi_addr,
  input  logic [LEN_WIDTH-1:0]       s_axis_req_len,
  input  logic                       s_axis_req_valid,
  output logic                       s_axis_req_ready,

  output logic [PCIE_ADDR_WIDTH-1:0] m_axis_desc_pcie_addr,
  output logic [AXI_ADDR_WIDTH-1:0]  m_axis_desc_axi_addr,
  output logic [LEN_WIDTH-1:0]       m_axis_desc_len,
  output logic [TAG_WIDTH-1:0]       m_axis_desc_tag,
  output logic                       m_axis_desc_valid,
  input  logic                       m_axis_desc_ready,

  input  logic [TAG_WIDTH-1:0]       s_axis_desc_status_tag,
  input  logic [3:0]                 s_axis_desc_status_error,
  input  logic                       s_axis_desc_status_valid,

  output logic [TAG_WIDTH-1:0]       m_axis_cpl_tag,
  output logic [3:0]                 m_axis_cpl_error,
  output logic                       m_axis_cpl_valid,
  input  logic                       m_axis_cpl_ready,

  output logic [TAG_WIDTH:0]         outstanding,
  output logic                       busy,
  output logic                       spurious_status
);

  localparam int DEPTH = 2**TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] MAX_OUT = (TAG_WIDTH+1)'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > DEPTH) begin : g_bad_max_outstanding
    $error("MAX_OUTSTANDING must lie in 1..2**TAG_WIDTH");
  end

  // The extra pointer bit tells a full ring apart from an empty one.
  logic [TAG_WIDTH:0]   head;
  logic [TAG_WIDTH:0]   tail;
  logic [TAG_WIDTH-1:0] head_idx;
  logic [DEPTH-1:0]     done;
  logic [3:0]           err_mem [DEPTH];

  logic                 accept;
  logic [TAG_WIDTH-1:0] status_dist;
  logic                 status_in_flight;
  logic                 status_ok;
  logic                 retire;

  assign head_idx    = head[TAG_WIDTH-1:0];
  assign outstanding = tail - head;

  assign s_axis_req_ready = enable && (outstanding < MAX_OUT) &&
                            (!m_axis_desc_valid || m_axis_desc_ready);
  assign accept = s_axis_req_valid && s_axis_req_ready;

  // Distance from the head in ring order; anything closer than the occupancy is in flight.
  assign status_dist      = s_axis_desc_status_tag - head_idx;
  assign status_in_flight = {1'b0, status_dist} < outstanding;
  assign status_ok        = s_axis_desc_status_valid && status_in_flight &&
                            !done[s_axis_desc_status_tag];

  assign retire = (outstanding != '0) && done[head_idx] &&
                  (!m_axis_cpl_valid || m_axis_cpl_ready);

  assign busy = (outstanding != '0) || m_axis_desc_valid || m_axis_cpl_valid;

  // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head                  <= '0;
      tail                  <= '0;
      done                  <= '0;
      m_axis_desc_pcie_addr <= '0;
      m_axis_desc_axi_addr  <= '0;
      m_axis_desc_len       <= '0;
      m_axis_desc_tag       <= '0;
      m_axis_desc_valid     <= 1'b0;
      m_axis_cpl_tag        <= '0;
      m_axis_cpl_error      <= '0;
      m_axis_cpl_valid      <= 1'b0;
      spurious_status       <= 1'b0;
    end else begin
      if (accept) begin
        m_axis_desc_pcie_addr <= s_axis_req_pcie_addr;
        m_axis_desc_axi_addr  <= s_axis_req_axi_addr;
        m_axis_desc_len       <= s_axis_req_len;
        m_axis_desc_tag       <= tail[TAG_WIDTH-1:0];
        m_axis_desc_valid     <= 1'b1;
        tail                  <= tail + 1'b1;
      end else if (m_axis_desc_ready) begin
        m_axis_desc_valid <= 1'b0;
      end

      if (s_axis_desc_status_valid && !status_ok) begin
        spurious_status <= 1'b1;
      end

      // A status write and a retire never target the same bit: retire needs done, status needs !done.
      if (status_ok) begin
        done[s_axis_desc_status_tag] <= 1'b1;
      end

      if (retire) begin
        done[head_idx]   <= 1'b0;
        m_axis_cpl_tag   <= head_idx;
        m_axis_cpl_error <= err_mem[head_idx];
        m_axis_cpl_valid <= 1'b1;
        head             <= head + 1'b1;
      end else if (m_axis_cpl_ready) begin
        m_axis_cpl_valid <= 1'b0;
      end
    end
  end

  // NOTE: the error store is deliberately not reset; an entry is only read once its done bit is set.
  always_ff @(posedge clk) begin
    if (status_ok) begin
      err_mem[s_axis_desc_status_tag] <= s_axis_desc_status_error;
    end
  end

endmodule

// File: tb/tb_pcie_dma_desc_issue_ctrl.sv
// Bench for pcie_dma_desc_issue_ctrl: a directed table, hand-written corner sequences and
// random traffic, all checked against a queue-based transaction model.
module tb_pcie_dma_desc_issue_ctrl;

  localparam int TW   = 3;
  localparam int MAXO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [63:0]   s_axis_req_pcie_addr;
  logic [15:0]   s_axis_req_axi_addr;
  logic [19:0]   s_axis_req_len;
  logic          s_axis_req_valid;
  logic          s_axis_req_ready;
  logic [63:0]   m_axis_desc_pcie_addr;
  logic [15:0]   m_axis_desc_axi_addr;
  logic [19:0]   m_axis_desc_len;
  logic [TW-1:0] m_axis_desc_tag;
  logic          m_axis_desc_valid;
  logic          m_axis_desc_ready;
  logic [TW-1:0] s_axis_desc_status_tag;
  logic [3:0]    s_axis_desc_status_error;
  logic          s_axis_desc_status_valid;
  logic [TW-1:0] m_axis_cpl_tag;
  logic [3:0]    m_axis_cpl_error;
  logic          m_axis_cpl_valid;
  logic          m_axis_cpl_ready;
  logic [TW:0]   outstanding;
  logic          busy;
  logic          spurious_status;

  pcie_dma_desc_issue_ctrl #(
    .PCIE_ADDR_WIDTH(64), .AXI_ADDR_WIDTH(16), .LEN_WIDTH(20),
    .TAG_WIDTH(TW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_req_pcie_addr(s_axis_req_pcie_addr), .s_axis_req_axi_addr(s_axis_req_axi_addr),
    .s_axis_req_len(s_axis_req_len), .s_axis_req_valid(s_axis_req_valid),
    .s_axis_req_ready(s_axis_req_ready),
    .m_axis_desc_pcie_addr(m_axis_desc_pcie_addr), .m_axis_desc_axi_addr(m_axis_desc_axi_addr),
    .m_axis_desc_len(m_axis_desc_len), .m_axis_desc_tag(m_axis_desc_tag),
    .m_axis_desc_valid(m_axis_desc_valid), .m_axis_desc_ready(m_axis_desc_ready),
    .s_axis_desc_status_tag(s_axis_desc_status_tag),
    .s_axis_desc_status_error(s_axis_desc_status_error),
    .s_axis_desc_status_valid(s_axis_desc_status_valid),
    .m_axis_cpl_tag(m_axis_cpl_tag), .m_axis_cpl_error(m_axis_cpl_error),
    .m_axis_cpl_valid(m_axis_cpl_valid), .m_axis_cpl_ready(m_axis_cpl_ready),
    .outstanding(outstanding), .busy(busy), .spurious_status(spurious_status)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: in-flight tags kept as an issue-ordered queue.
  typedef struct {
    logic [TW-1:0] tag;
    bit            done;
    logic [3:0]    err;
  } ent_t;

  ent_t          fl[$];
  int unsigned   m_next_tag;
  bit            m_dv;
  logic [63:0]   m_dpa;
  logic [15:0]   m_daa;
  logic [19:0]   m_dlen;
  logic [TW-1:0] m_dtag;
  bit            m_cv;
  logic [TW-1:0] m_ctag;
  logic [3:0]    m_cerr;
  bit            m_spur;

  logic [TW-1:0] got_tag[$];
  logic [3:0]    got_err[$];
  int            got_cyc[$];

  function automatic bit model_ready();
    return enable && (fl.size() < MAXO) && (!m_dv || m_axis_desc_ready);
  endfunction

  task automatic model_step();
    bit acc, ret;
    int idx;
    if (rst) begin
      fl.delete();
      m_next_tag = 0;
      m_dv = 0; m_dpa = '0; m_daa = '0; m_dlen = '0; m_dtag = '0;
      m_cv = 0; m_ctag = '0; m_cerr = '0; m_spur = 0;
      return;
    end
    acc = s_axis_req_valid && model_ready();
    ret = (fl.size() > 0) && fl[0].done && (!m_cv || m_axis_cpl_ready);
    idx = -1;
    if (s_axis_desc_status_valid) begin
      foreach (fl[i]) if (fl[i].tag == s_axis_desc_status_tag) idx = i;
      if (idx >= 0 && !fl[idx].done) begin
        fl[idx].done = 1;
        fl[idx].err  = s_axis_desc_status_error;
      end else begin
        m_spur = 1;
      end
    end
    if (ret) begin
      m_cv = 1; m_ctag = fl[0].tag; m_cerr = fl[0].err;
      void'(fl.pop_front());
    end else if (m_axis_cpl_ready) begin
      m_cv = 0;
    end
    if (acc) begin
      fl.push_back('{tag: TW'(m_next_tag), done: 0, err: 4'd0});
      m_dv = 1; m_dpa = s_axis_req_pcie_addr; m_daa = s_axis_req_axi_addr;
      m_dlen = s_axis_req_len; m_dtag = TW'(m_next_tag);
      m_next_tag = (m_next_tag + 1) % (1 << TW);
    end else if (m_axis_desc_ready) begin
      m_dv = 0;
    end
  endtask

  // One clock: pre-edge ready check and bookkeeping, model step, post-edge output checks.
  task automatic cycle();
    #1;
    if (!rst) begin
      check("req_ready", s_axis_req_ready, model_ready());
      if (s_axis_req_valid && s_axis_req_ready) n_acc++;
      if (m_axis_cpl_valid && m_axis_cpl_ready) begin
        got_tag.push_back(m_axis_cpl_tag);
        got_err.push_back(m_axis_cpl_error);
        got_cyc.push_back(cyc);
      end
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("desc_valid", m_axis_desc_valid, m_dv);
    if (m_dv) begin
      check("desc_tag", m_axis_desc_tag, m_dtag);
      check("desc_pcie_addr", m_axis_desc_pcie_addr, m_dpa);
      check("desc_axi_addr", m_axis_desc_axi_addr, m_daa);
      check("desc_len", m_axis_desc_len, m_dlen);
    end
    check("cpl_valid", m_axis_cpl_valid, m_cv);
    if (m_cv) begin
      check("cpl_tag", m_axis_cpl_tag, m_ctag);
      check("cpl_error", m_axis_cpl_error, m_cerr);
    end
    check("outstanding", outstanding, fl.size());
    check("busy", busy, (fl.size() != 0) || m_dv || m_cv);
    check("spurious", spurious_status, m_spur);
  endtask

  task automatic idle_inputs();
    rst = 0; enable = 1;
    s_axis_req_valid = 0; m_axis_desc_ready = 1;
    s_axis_desc_status_valid = 0; s_axis_desc_status_tag = '0; s_axis_desc_status_error = '0;
    m_axis_cpl_ready = 1;
  endtask

  task automatic new_fields();
    s_axis_req_pcie_addr = {$urandom, $urandom};
    s_axis_req_axi_addr  = 16'($urandom);
    s_axis_req_len       = 20'($urandom);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic status(input int tag, input int err);
    s_axis_desc_status_valid = 1;
    s_axis_desc_status_tag   = TW'(tag);
    s_axis_desc_status_error = 4'(err);
    cycle();
    s_axis_desc_status_valid = 0;
  endtask

  task automatic clear_got();
    got_tag.delete(); got_err.delete(); got_cyc.delete();
  endtask

  typedef struct {
    bit rst, rv, dr, sv;
    logic [TW-1:0] stag;
    logic [3:0] serr;
    bit cr;
    bit exp_ready, exp_dv;
    logic [TW-1:0] exp_dtag;
    bit exp_cv;
    logic [TW-1:0] exp_ctag;
    logic [3:0] exp_cerr;
    logic [TW:0] exp_out;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [63:0] first_pa;
    logic [15:0] first_aa;
    logic [19:0] first_len;

    // rst rv dr sv stag serr cr | ready dv dtag cv ctag cerr out
    vecs[0] = '{1, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 1, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 1};
    vecs[2] = '{0, 1, 1, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 2};
    vecs[3] = '{0, 1, 1, 0, 0, 0, 1,  1, 1, 2, 0, 0, 0, 3};
    vecs[4] = '{0, 0, 1, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 3};
    vecs[5] = '{0, 0, 1, 1, 1, 0, 1,  1, 0, 0, 1, 0, 0, 2};
    vecs[6] = '{0, 0, 1, 1, 2, 0, 1,  1, 0, 0, 1, 1, 0, 1};
    vecs[7] = '{0, 0, 1, 0, 0, 0, 1,  1, 0, 0, 1, 2, 0, 0};
    vecs[8] = '{0, 0, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0};

    idle_inputs();
    new_fields();

    // Reset, three back-to-back requests, in-order status, in-order completions.
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst;
      s_axis_req_valid = vecs[i].rv;
      m_axis_desc_ready = vecs[i].dr;
      s_axis_desc_status_valid = vecs[i].sv;
      s_axis_desc_status_tag = vecs[i].stag;
      s_axis_desc_status_error = vecs[i].serr;
      m_axis_cpl_ready = vecs[i].cr;
      s_axis_req_pcie_addr = 64'h0000_1000_0000_0000 + 64'(i);
      s_axis_req_axi_addr = 16'h2000 + 16'(i);
      s_axis_req_len = 20'h100 * 20'(i + 1);
      #1;
      if (!vecs[i].rst) check($sformatf("vec%0d_ready", i), s_axis_req_ready, vecs[i].exp_ready);
      cycle();
      check($sformatf("vec%0d_dv", i), m_axis_desc_valid, vecs[i].exp_dv);
      if (vecs[i].exp_dv) check($sformatf("vec%0d_dtag", i), m_axis_desc_tag, vecs[i].exp_dtag);
      check($sformatf("vec%0d_cv", i), m_axis_cpl_valid, vecs[i].exp_cv);
      if (vecs[i].exp_cv) begin
        check($sformatf("vec%0d_ctag", i), m_axis_cpl_tag, vecs[i].exp_ctag);
        check($sformatf("vec%0d_cerr", i), m_axis_cpl_error, vecs[i].exp_cerr);
      end
      check($sformatf("vec%0d_out", i), outstanding, vecs[i].exp_out);
    end

    // Out-of-order status 3,1,2(err 5),0 still completes 0,1,2,3.
    do_reset();
    s_axis_req_valid = 1;
    for (int i = 0; i < 4; i++) begin new_fields(); cycle(); end
    s_axis_req_valid = 0;
    clear_got();
    status(3, 0); status(1, 0); status(2, 5); status(0, 0);
    for (int i = 0; i < 6; i++) cycle();
    check("ooo_count", got_tag.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_tag.size()) begin
        check($sformatf("ooo_tag%0d", i), got_tag[i], i);
        check($sformatf("ooo_err%0d", i), got_err[i], (i == 2) ? 5 : 0);
      end
    end

    // Fill the ring, then one retire frees a slot and the tag wraps to 0.
    do_reset();
    s_axis_req_valid = 1;
    for (int i = 0; i < MAXO; i++) begin new_fields(); cycle(); end
    #1;
    check("full_ready", s_axis_req_ready, 0);
    check("full_out", outstanding, MAXO);
    s_axis_req_valid = 0;
    status(0, 0);
    s_axis_req_valid = 1;
    #1;
    check("full_ready_before_retire", s_axis_req_ready, 0);
    s_axis_req_valid = 0;
    cycle();
    s_axis_req_valid = 1;
    new_fields();
    #1;
    check("ready_after_retire", s_axis_req_ready, 1);
    check("out_after_retire", outstanding, MAXO - 1);
    cycle();
    check("wrap_tag", m_axis_desc_tag, 0);
    check("wrap_valid", m_axis_desc_valid, 1);
    s_axis_req_valid = 0;
    cycle();

    // Stalled sink: one accept, held descriptor fields stay stable.
    do_reset();
    m_axis_desc_ready = 0;
    s_axis_req_valid = 1;
    n_acc = 0;
    new_fields();
    first_pa = s_axis_req_pcie_addr; first_aa = s_axis_req_axi_addr; first_len = s_axis_req_len;
    for (int i = 0; i < 5; i++) begin
      cycle();
      new_fields();
    end
    check("stall_accepts", n_acc, 1);
    check("stall_out", outstanding, 1);
    check("stall_pa", m_axis_desc_pcie_addr, first_pa);
    check("stall_aa", m_axis_desc_axi_addr, first_aa);
    check("stall_len", m_axis_desc_len, first_len);
    s_axis_req_valid = 0;
    m_axis_desc_ready = 1;
    cycle();

    // Spurious status: idle tag, reset clear, duplicate status, status after mid-flight reset.
    do_reset();
    status(7, 0);
    check("spur_idle", spurious_status, 1);
    check("spur_idle_nocpl", m_axis_cpl_valid, 0);
    do_reset();
    check("spur_cleared", spurious_status, 0);
    s_axis_req_valid = 1;
    cycle(); cycle();
    s_axis_req_valid = 0;
    status(1, 3);
    check("spur_first_ok", spurious_status, 0);
    status(1, 4);
    check("spur_dup", spurious_status, 1);
    check("spur_dup_nocpl", m_axis_cpl_valid, 0);
    do_reset();
    s_axis_req_valid = 1;
    cycle(); cycle();
    s_axis_req_valid = 0;
    do_reset();
    status(0, 0);
    check("spur_after_rst", spurious_status, 1);
    check("spur_after_rst_out", outstanding, 0);

    // Completion backpressure, then three retires on consecutive cycles.
    do_reset();
    s_axis_req_valid = 1;
    for (int i = 0; i < 3; i++) begin new_fields(); cycle(); end
    s_axis_req_valid = 0;
    m_axis_cpl_ready = 0;
    status(0, 1); status(1, 2); status(2, 3);
    for (int i = 0; i < 3; i++) cycle();
    check("bp_cpl_valid", m_axis_cpl_valid, 1);
    check("bp_cpl_tag", m_axis_cpl_tag, 0);
    clear_got();
    m_axis_cpl_ready = 1;
    for (int i = 0; i < 5; i++) cycle();
    check("bp_count", got_tag.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_tag.size()) begin
        check($sformatf("bp_tag%0d", i), got_tag[i], i);
        check($sformatf("bp_err%0d", i), got_err[i], i + 1);
      end
    end
    if (got_cyc.size() == 3) check("bp_consecutive", got_cyc[2] - got_cyc[0], 2);
    check("bp_out_end", outstanding, 0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int cand[$];
      int r;
      enable = ($urandom_range(0, 9) != 0);
      s_axis_req_valid = ($urandom_range(0, 2) != 0);
      m_axis_desc_ready = ($urandom_range(0, 3) != 0);
      m_axis_cpl_ready = ($urandom_range(0, 3) != 0);
      new_fields();
      foreach (fl[i]) if (!fl[i].done) cand.push_back(int'(fl[i].tag));
      r = $urandom_range(0, 99);
      s_axis_desc_status_valid = 0;
      s_axis_desc_status_error = 4'($urandom);
      if (cand.size() > 0 && r < 45) begin
        s_axis_desc_status_valid = 1;
        s_axis_desc_status_tag = TW'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if (r == 99) begin
        s_axis_desc_status_valid = 1;
        s_axis_desc_status_tag = TW'($urandom);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
